fitness_sequencer: RTL

Sequencer that evaluates one genetic-circuit candidate against a target truth table. It shifts a chromosome in serially and drives it in parallel to the phenotype block. It then sweeps every input vector through the phenotype, compares each phenotype output with the target bit, and reports the match count as fitness. It sits between the serial chromosome source (GA engine or host link) and the combinational phenotype datapath.

---
 rtl/genetic_pkg.sv | 10 +
 rtl/chrom_shift_reg.sv | 19 +
 rtl/fitness_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/genetic_pkg.sv
// Shared sizing constants and state type for the fitness sequencer.
package genetic_pkg;
  localparam int CHROM_W = 260;
  localparam int N_IN    = 4;
  localparam int N_VEC   = 1 << N_IN;
  localparam int FIT_W   = $clog2(N_VEC + 1);
  localparam int CNT_W   = $clog2(CHROM_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EVAL, S_DONE} seq_state_e;
endpackage

// File: rtl/chrom_shift_reg.sv
// Serial-in parallel-out chromosome register, MSB arrives first.
module chrom_shift_reg #(
  parameter int W = 260
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         bit_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q_q <= '0;
    else if (en_i) q_q <= {q_q[W-2:0], bit_i};
  end

  assign q_o = q_q;
endmodule

// File: rtl/fitness_sequencer.sv
// Loads a chromosome serially, sweeps all phenotype input vectors and scores
// matches against the target truth table. FITNESS_ERROR_MAP_EN enables error_map.
module fitness_sequencer
  import genetic_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [N_VEC-1:0]   target,
  input  logic               ser_valid,
  input  logic               ser_bit,
  output logic               ser_ready,
  output logic [CHROM_W-1:0] chrom_o,
  output logic [N_IN-1:0]    inp_o,
  input  logic               pheno_out,
  output logic               busy,
  output logic               done,
  output logic [FIT_W-1:0]   fitness,
  output logic [N_VEC-1:0]   error_map
);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  seq_state_e       state_q, state_d;
  logic [N_VEC-1:0] tgt_q, tgt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_IN-1:0]  vec_q, vec_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [FIT_W-1:0] acc_q, acc_d;
  logic [FIT_W-1:0] fit_q, fit_d;
  logic             shift_en;
  logic             hit;
`ifdef FITNESS_ERROR_MAP_EN
  logic [N_VEC-1:0] err_q, err_d;
  logic [N_VEC-1:0] emap_q, emap_d;
`endif

  chrom_shift_reg #(.W(CHROM_W)) u_chrom (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (shift_en),
    .bit_i (ser_bit),
    .q_o   (chrom_o)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      tgt_q    <= '0;
      cnt_q    <= '0;
      vec_q    <= '0;
      settle_q <= '0;
      acc_q    <= '0;
      fit_q    <= '0;
`ifdef FITNESS_ERROR_MAP_EN
      err_q    <= '0;
      emap_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      cnt_q    <= cnt_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
      acc_q    <= acc_d;
      fit_q    <= fit_d;
`ifdef FITNESS_ERROR_MAP_EN
      err_q    <= err_d;
      emap_q   <= emap_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    cnt_d    = cnt_q;
    vec_d    = vec_q;
    settle_d = settle_q;
    acc_d    = acc_q;
    fit_d    = fit_q;
    shift_en = 1'b0;
    hit      = (pheno_out == tgt_q[vec_q]);
`ifdef FITNESS_ERROR_MAP_EN
    err_d    = err_q;
    emap_d   = emap_q;
`endif
    case (state_q)
      S_IDLE: if (start) begin
        tgt_d    = target;
        cnt_d    = '0;
        acc_d    = '0;
        vec_d    = '0;
        settle_d = '0;
`ifdef FITNESS_ERROR_MAP_EN
        err_d    = '0;
`endif
        state_d  = S_LOAD;
      end
      S_LOAD: if (ser_valid) begin
        shift_en = 1'b1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(CHROM_W - 1)) begin
          vec_d    = '0;
          settle_d = '0;
          state_d  = S_EVAL;
        end
      end
      S_EVAL: begin
        if (settle_q == SW'(SETTLE - 1)) begin
          settle_d = '0;
          if (hit) acc_d = acc_q + FIT_W'(1);
`ifdef FITNESS_ERROR_MAP_EN
          else     err_d[vec_q] = 1'b1;
`endif
          // Results are committed on the last sample so they are valid during DONE.
          if (vec_q == N_IN'(N_VEC - 1)) begin
            fit_d   = acc_d;
`ifdef FITNESS_ERROR_MAP_EN
            emap_d  = err_d;
`endif
            state_d = S_DONE;
          end else begin
            vec_d = vec_q + N_IN'(1);
          end
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign ser_ready = (state_q == S_LOAD);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign inp_o     = vec_q;
  assign fitness   = fit_q;
`ifdef FITNESS_ERROR_MAP_EN
  assign error_map = emap_q;
`else
  assign error_map = '0;
`endif
endmodule
